// File: rtl/conv_bias_streamer.sv
// conv_bias_streamer: pulls NUM_WORDS bias words over valid/ready and replays them as a strobed stream
// with a sticky done flag and a running XOR checksum.
module conv_bias_streamer #(
    parameter int DATA_W    = 16,
    parameter int NUM_WORDS = 32,
    parameter int IDX_W     = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_src_data,
    input  logic              i_src_valid,
    output logic              o_src_ready,
    output logic [DATA_W-1:0] o_data_output,
    output logic              o_data_valid,
    output logic [IDX_W-1:0]  o_word_idx,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [IDX_W:0] LAST = (IDX_W+1)'(NUM_WORDS-1);
    state_t            r_state;
    state_t            w_next;
    logic              r_start_d;
    logic [IDX_W:0]    r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_cksum;
    logic              w_start_edge;
    logic              w_hs;

    assign w_start_edge = i_start & ~r_start_d;
    assign w_hs         = i_src_valid & (r_state == LOAD);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // src_ready depends only on the registered state, never on src_valid
    always_comb begin
        w_next      = r_state;
        o_src_ready = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: w_next = w_start_edge ? LOAD : IDLE;
            LOAD: begin
                o_src_ready = 1'b1;
                o_busy      = 1'b1;
                w_next      = (w_hs && r_cnt == LAST) ? DONE : LOAD;
            end
            DONE: begin
                o_done = 1'b1;
                w_next = w_start_edge ? LOAD : DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_start_d <= 1'b0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_cksum   <= '0;
        end else begin
            r_start_d <= i_start;
            r_valid   <= w_hs;
            if (w_hs) begin
                r_data  <= i_src_data;
                r_idx   <= r_cnt[IDX_W-1:0];
                r_cksum <= r_cksum ^ i_src_data;
                r_cnt   <= r_cnt + 1'b1;
            end
            if (w_start_edge && r_state != LOAD) begin
                r_cnt   <= '0;
                r_cksum <= '0;
            end
        end
    end

    assign o_data_output = r_data;
    assign o_data_valid  = r_valid;
    assign o_word_idx    = r_idx;
    assign o_checksum    = r_cksum;
endmodule

// File: tb/tb_conv_bias_streamer.sv
// tb_conv_bias_streamer: scoreboard bench; accepted words are queued at handshake and
// compared against each data_valid pulse.
module tb_conv_bias_streamer;
    localparam int DW = 16;
    localparam int NW = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] data_output;
    logic          data_valid;
    logic [IW-1:0] word_idx;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;

    conv_bias_streamer #(.DATA_W(DW), .NUM_WORDS(NW), .IDX_W(IW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_src_data(src_data),
        .i_src_valid(src_valid), .o_src_ready(src_ready), .o_data_output(data_output),
        .o_data_valid(data_valid), .o_word_idx(word_idx), .o_busy(busy), .o_done(done),
        .o_checksum(checksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] exp_ck = '0;
    logic [DW-1:0] words[64];
    int            n_acc = 0;
    int            n_pulses = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pop before push: a pulse seen now always belongs to an earlier handshake
    always @(negedge clk) begin
        if (data_valid) begin
            n_pulses++;
            if (sb.size() == 0) check("spurious_valid", 1, 0);
            else begin
                e = sb.pop_front();
                check("data", 32'(data_output), 32'(e.d));
                check("idx", 32'(word_idx), 32'(e.idx));
                check("done_at_pulse", 32'(done), 32'(e.idx == IW'(NW-1)));
            end
        end
        if (rst_n && src_valid && src_ready) begin
            sb.push_back('{idx: IW'(n_acc), d: src_data});
            exp_ck ^= src_data;
            n_acc++;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, 32'(data_output), 0);
        check({tag, "_dvalid"}, 32'(data_valid), 0);
        check({tag, "_idx"}, 32'(word_idx), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_cksum"}, 32'(checksum), 0);
        check({tag, "_ready"}, 32'(src_ready), 0);
    endtask

    task automatic run(input int avail, input bit gap, input int abort_at);
        int k = 0;
        int cyc = 0;
        bit hs;
        n_acc = 0;
        exp_ck = '0;
        n_pulses = 0;
        start = 1'b1;
        @(posedge clk); #1;
        check("busy_after_start", 32'(busy), 1);
        check("done_cleared", 32'(done), 0);
        while (k < avail && cyc < 400 && !done && !(abort_at > 0 && k == abort_at)) begin
            src_valid = gap ? (cyc % 2 == 0) : 1'b1;
            src_data  = words[k];
            @(negedge clk);
            hs = src_valid && src_ready;
            @(posedge clk); #1;
            if (hs) k++;
            cyc++;
        end
        if (cyc >= 400) check("timeout", 0, 1);
        if (abort_at > 0) begin
            src_valid = 1'b0;
            return;
        end
        src_valid = 1'b1;
        src_data  = words[k];
        repeat (4) begin
            @(negedge clk);
            check("ready_in_done", 32'(src_ready), 0);
        end
        src_valid = 1'b0;
        #1;
        check("accepted", k, NW);
        check("pulses", n_pulses, NW);
        check("sb_empty", sb.size(), 0);
        check("checksum", 32'(checksum), 32'(exp_ck));
        check("done_final", 32'(done), 1);
        check("busy_final", 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) words[i] = DW'(i + 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(NW, 1'b0, 0);
        check("checksum_const", 32'(checksum), 32'h0020);

        repeat (100) @(posedge clk);
        #1;
        check("held_done", 32'(done), 1);
        check("held_busy", 32'(busy), 0);
        check("held_pulses", n_pulses, NW);

        start = 1'b0;
        @(posedge clk); #1;
        run(NW, 1'b1, 0);

        start = 1'b0;
        @(posedge clk); #1;
        run(40, 1'b0, 0);

        start = 1'b0;
        for (int i = 0; i < 64; i++) words[i] = 16'hFFFF;
        @(posedge clk); #1;
        run(NW, 1'b0, 0);
        check("checksum_ffff", 32'(checksum), 0);

        start = 1'b0;
        for (int i = 0; i < 64; i++) words[i] = DW'(16'h0100 + i);
        @(posedge clk); #1;
        run(NW, 1'b0, 10);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("midrun");
        check("abort_pulses", n_pulses, 10);
        check("abort_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_pulse", n_pulses, 10);
        run(NW, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
